// File: rtl/eth_pkg.sv
// Shared Ethernet/XGMII definitions for the RX and TX MACs.
package eth_pkg;

  // XGMII control characters
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  // Preamble and start-of-frame delimiter bytes
  localparam logic [7:0] ETH_HDR = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;

  // CRC register value left after running data plus a correct FCS (no final XOR)
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // 32-bit XGMII words that open a frame: START + 3 preamble bytes, then 3 preamble + SFD
  localparam logic [31:0] START_WORD = {ETH_HDR, ETH_HDR, ETH_HDR, XGMII_START};
  localparam logic [31:0] SFD_WORD   = {ETH_SFD, ETH_HDR, ETH_HDR, ETH_HDR};
  localparam logic [31:0] IDLE_WORD  = {4{XGMII_IDLE}};

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    LAST,
    DROP
  } state_t;

  // One byte of reflected CRC-32 (poly 0x04C11DB7, LSB first)
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32.sv
// Ethernet CRC-32 accumulator with per-lane byte enables; lanes are folded in from lane 0 up.
module crc32
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] lane_valid,
  output logic [31:0]             crc
);

  localparam int Bytes = DATA_WIDTH / 8;

  logic [31:0] crc_q, crc_d;

  // Next CRC: re-seed on init, otherwise fold in each enabled lane in order
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = 32'hFFFFFFFF;
    end else if (en) begin
      for (int i = 0; i < Bytes; i++) begin
        if (lane_valid[i]) crc_d = crc32_byte(crc_d, data[8*i +: 8]);
      end
    end
  end

  // CRC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 32'hFFFFFFFF;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/rx_mac.sv
// Receive MAC: XGMII in, preamble/SFD/FCS stripped, payload out on AXI-Stream with frame status.
module rx_mac
  import eth_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = 4,
  parameter int AXIS_KEEP_WIDTH  = XGMII_DATA_WIDTH / 8,
  parameter int MIN_FRAME_BYTES  = 64,
  parameter int MAX_FRAME_BYTES  = 1518
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_rxd,
  input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
  input  logic                        i_xgmii_valid,
  output logic [XGMII_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        o_crc_err,
  output logic                        o_frame_err
);

  localparam logic [10:0] CntMax = 11'd2047;
  localparam logic [10:0] MinB   = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MaxB   = 11'(MAX_FRAME_BYTES);

  state_t                      state_q, state_d;
  logic [XGMII_DATA_WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic                        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [10:0]                 cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [1:0]                  k_q, k_d;

  logic [XGMII_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [AXIS_KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
  logic                        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                        crc_err_q, crc_err_d, frame_err_q, frame_err_d;

  logic [1:0]                  first_ctrl;
  logic                        has_fd, is_term, is_start;
  logic [XGMII_CTRL_WIDTH-1:0] crc_lane_vld;
  logic [2:0]                  add_bytes;
  logic [11:0]                 cnt_sum;
  logic [10:0]                 cnt_sat;
  logic                        crc_init, crc_en;
  logic [31:0]                 crc_val;
  logic                        crc_bad, frame_bad;
  logic [AXIS_KEEP_WIDTH-1:0]  last_keep;
  logic [XGMII_DATA_WIDTH-1:0] last_data;

  crc32 #(
    .DATA_WIDTH (XGMII_DATA_WIDTH)
  ) u_crc32 (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .init       (crc_init),
    .en         (crc_en),
    .data       (i_xgmii_rxd),
    .lane_valid (crc_lane_vld),
    .crc        (crc_val)
  );

  // Word decode: lowest control lane, TERM/START detection, CRC lane enables, byte count
  always_comb begin
    first_ctrl = '0;
    has_fd     = 1'b0;
    for (int i = XGMII_CTRL_WIDTH - 1; i >= 0; i--) begin
      if (i_xgmii_ctrl[i]) first_ctrl = 2'(i);
    end
    for (int i = 0; i < XGMII_CTRL_WIDTH; i++) begin
      if (i_xgmii_ctrl[i] && i_xgmii_rxd[8*i +: 8] == XGMII_TERM) has_fd = 1'b1;
    end
    is_term  = (|i_xgmii_ctrl) && (i_xgmii_rxd[8*first_ctrl +: 8] == XGMII_TERM);
    is_start = i_xgmii_ctrl[0] && (i_xgmii_rxd[7:0] == XGMII_START);
    for (int i = 0; i < XGMII_CTRL_WIDTH; i++) begin
      crc_lane_vld[i] = !i_xgmii_ctrl[i] && (!is_term || (i < int'(first_ctrl)));
    end
    // Non-TERM words always occupy a full pipeline slot, even when they carry error chars
    add_bytes = is_term ? {1'b0, first_ctrl} : 3'd4;
    cnt_sum   = {1'b0, cnt_q} + {9'b0, add_bytes};
    cnt_sat   = (cnt_sum > {1'b0, CntMax}) ? CntMax : cnt_sum[10:0];
  end

  // Frame status and final partial beat; cnt_q/crc_val already cover every frame byte here
  always_comb begin
    crc_bad   = (crc_val != CRC_RESIDUE);
    frame_bad = (cnt_q < MinB) || (cnt_q > MaxB) || err_q;
    last_keep = AXIS_KEEP_WIDTH'((1 << k_q) - 1);
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      last_data[8*i +: 8] = last_keep[i] ? s1_q[8*i +: 8] : 8'h00;
    end
  end

  // Next-state, holdback pipeline and output beat selection
  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s1_vld_d    = s1_vld_q;
    s2_vld_d    = s2_vld_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    k_d         = k_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    tdata_d     = '0;
    tkeep_d     = '0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_xgmii_valid && i_xgmii_ctrl == 4'h1 && i_xgmii_rxd == START_WORD) begin
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (i_xgmii_valid) begin
          if (i_xgmii_ctrl == '0 && i_xgmii_rxd == SFD_WORD) begin
            state_d  = DATA;
            crc_init = 1'b1;
            cnt_d    = '0;
            err_d    = 1'b0;
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
          end else begin
            state_d     = DROP;
            frame_err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (i_xgmii_valid) begin
          if (is_start) begin
            // A new START cuts the frame short; flush the oldest held word as a bad tlast
            state_d     = IDLE;
            frame_err_d = 1'b1;
            s1_vld_d    = 1'b0;
            s2_vld_d    = 1'b0;
            if (s1_vld_q || s2_vld_q) begin
              tvalid_d = 1'b1;
              tdata_d  = s2_vld_q ? s2_q : s1_q;
              tkeep_d  = '1;
              tlast_d  = 1'b1;
              tuser_d  = 1'b1;
            end
          end else if (is_term) begin
            crc_en   = 1'b1;
            cnt_d    = cnt_sat;
            s2_vld_d = 1'b0;
            if (cnt_sum <= 12'd4) begin
              state_d     = IDLE;
              s1_vld_d    = 1'b0;
              frame_err_d = 1'b1;
            end else if (first_ctrl == 2'd0) begin
              // s1 is the whole FCS, so s2 is the final payload beat
              state_d     = IDLE;
              s1_vld_d    = 1'b0;
              tvalid_d    = 1'b1;
              tdata_d     = s2_q;
              tkeep_d     = '1;
              tlast_d     = 1'b1;
              tuser_d     = crc_bad || frame_bad;
              crc_err_d   = crc_bad;
              frame_err_d = frame_bad;
            end else begin
              // FCS straddles s1 and this word; s1 still holds k payload bytes
              state_d = LAST;
              k_d     = first_ctrl;
              if (s2_vld_q) begin
                tvalid_d = 1'b1;
                tdata_d  = s2_q;
                tkeep_d  = '1;
              end
            end
          end else begin
            crc_en   = 1'b1;
            cnt_d    = cnt_sat;
            if (|i_xgmii_ctrl) err_d = 1'b1;
            s1_d     = i_xgmii_rxd;
            s1_vld_d = 1'b1;
            s2_d     = s1_q;
            s2_vld_d = s1_vld_q;
            if (s2_vld_q) begin
              tvalid_d = 1'b1;
              tdata_d  = s2_q;
              tkeep_d  = '1;
            end
          end
        end
      end
      LAST: begin
        state_d     = IDLE;
        s1_vld_d    = 1'b0;
        tvalid_d    = 1'b1;
        tdata_d     = last_data;
        tkeep_d     = last_keep;
        tlast_d     = 1'b1;
        tuser_d     = crc_bad || frame_bad;
        crc_err_d   = crc_bad;
        frame_err_d = frame_bad;
      end
      DROP: begin
        if (i_xgmii_valid && (has_fd || (i_xgmii_ctrl == '1 && i_xgmii_rxd == IDLE_WORD))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pipeline and registered AXI-Stream outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      k_q         <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      k_q         <= k_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign o_crc_err     = crc_err_q;
  assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_rx_mac.sv
// Directed/random bench for rx_mac: frames are built from payload byte lists and checked
// against per-frame expectations derived from payload length and FCS correctness.
module tb_rx_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rxd;
  logic [3:0]  ctrl;
  logic        vld;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tuser, crc_err, frame_err;

  always #5 clk = ~clk;

  rx_mac dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_xgmii_rxd   (rxd),
    .i_xgmii_ctrl  (ctrl),
    .i_xgmii_valid (vld),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .o_crc_err     (crc_err),
    .o_frame_err   (frame_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    logic        cerr;
    logic        ferr;
  } beat_t;

  beat_t      got_q[$];
  int         crc_pulses = 0;
  int         ferr_pulses = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] pay[$];
  bit         gap_mode = 1'b0;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (tvalid) got_q.push_back('{tdata, tkeep, tlast, tuser, crc_err, frame_err});
    if (crc_err) crc_pulses++;
    if (frame_err) ferr_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference FCS: standard Ethernet CRC-32 over the payload, complemented
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pay[i]) begin
      c = c ^ {24'h0, pay[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [31:0] d);
    if (gap_mode) begin
      @(negedge clk);
      vld  = 1'b0;
      ctrl = 4'($urandom);
      rxd  = $urandom;
    end
    @(negedge clk);
    vld  = 1'b1;
    ctrl = c;
    rxd  = d;
  endtask

  // Sends START, preamble/SFD, payload+FCS, TERM and one idle; stop_at >= 0 aborts after that
  // data word
  task automatic send_frame(input bit bad_fcs, input bit bad_pre, input int stop_at);
    logic [7:0]  st[$];
    logic [31:0] fcs, w;
    logic [3:0]  c;
    int          nfull, r;
    fcs = ref_fcs();
    st  = pay;
    for (int j = 0; j < 4; j++) st.push_back(fcs[8*j +: 8]);
    if (bad_fcs) st[pay.size()] = st[pay.size()] ^ 8'hFF;
    drive(4'h1, 32'h555555FB);
    drive(4'h0, bad_pre ? 32'hD5555554 : 32'hD5555555);
    nfull = st.size() / 4;
    r     = st.size() % 4;
    for (int i = 0; i < nfull; i++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = st[4*i + j];
      drive(4'h0, w);
      if (i == stop_at) return;
    end
    w = 32'h07070707;
    for (int j = 0; j < r; j++) w[8*j +: 8] = st[4*nfull + j];
    w[8*r +: 8] = 8'hFD;
    c = 4'hF;
    c = c << r;
    drive(c, w);
    drive(4'hF, 32'h07070707);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input int plen, input bit bad, input int b,
                             input int cb, input int fb);
    int          total, nb;
    bit          runt, over, user;
    logic [31:0] ed;
    logic [3:0]  ek;
    beat_t       bt;
    total = plen + 4;
    runt  = total < 64;
    over  = total > 1518;
    user  = bad || runt || over;
    nb    = (plen + 3) / 4;
    chk($sformatf("%s beats", nm), 32'(got_q.size() - b), 32'(nb));
    if (got_q.size() - b == nb) begin
      for (int i = 0; i < nb; i++) begin
        ed = '0;
        ek = '0;
        for (int j = 0; j < 4; j++) begin
          if (4*i + j < plen) begin
            ed[8*j +: 8] = pay[4*i + j];
            ek[j]        = 1'b1;
          end
        end
        bt = got_q[b + i];
        chk($sformatf("%s data[%0d]", nm, i), bt.data, ed);
        chk($sformatf("%s keep[%0d]", nm, i), 32'(bt.keep), 32'(ek));
        chk($sformatf("%s last[%0d]", nm, i), 32'(bt.last), 32'(i == nb - 1));
      end
      bt = got_q[b + nb - 1];
      chk($sformatf("%s tuser", nm), 32'(bt.user), 32'(user));
      chk($sformatf("%s crc_err@tlast", nm), 32'(bt.cerr), 32'(bad));
      chk($sformatf("%s frame_err@tlast", nm), 32'(bt.ferr), 32'(runt || over));
    end
    chk($sformatf("%s crc pulses", nm), 32'(crc_pulses - cb), 32'(bad));
    chk($sformatf("%s frame_err pulses", nm), 32'(ferr_pulses - fb), 32'(runt || over));
  endtask

  task automatic fill(input int plen, input bit seq);
    pay.delete();
    for (int i = 0; i < plen; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
  endtask

  task automatic run_frame(input string nm, input int plen, input bit seq, input bit bad);
    int b, cb, fb;
    fill(plen, seq);
    b  = got_q.size();
    cb = crc_pulses;
    fb = ferr_pulses;
    send_frame(bad, 1'b0, -1);
    drain();
    check_frame(nm, plen, bad, b, cb, fb);
  endtask

  initial begin
    int b, cb, fb, nlast;
    rst_n = 1'b0;
    vld   = 1'b0;
    ctrl  = 4'hF;
    rxd   = 32'h07070707;
    repeat (3) @(negedge clk);
    chk("reset tvalid", 32'(tvalid), 32'd0);
    chk("reset tlast", 32'(tlast), 32'd0);
    chk("reset tuser", 32'(tuser), 32'd0);
    chk("reset tdata", tdata, 32'd0);
    chk("reset tkeep", 32'(tkeep), 32'd0);
    chk("reset crc_err", 32'(crc_err), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("p60", 60, 1'b1, 1'b0);
    run_frame("p61", 61, 1'b1, 1'b0);
    run_frame("p62", 62, 1'b1, 1'b0);
    run_frame("p63", 63, 1'b1, 1'b0);
    run_frame("p60_badfcs", 60, 1'b1, 1'b1);

    // Corrupted SFD: frame dropped, single frame_err, next frame intact
    fill(60, 1'b0);
    b  = got_q.size();
    cb = crc_pulses;
    fb = ferr_pulses;
    send_frame(1'b0, 1'b1, -1);
    drain();
    chk("badpre beats", 32'(got_q.size() - b), 32'd0);
    chk("badpre frame_err pulses", 32'(ferr_pulses - fb), 32'd1);
    chk("badpre crc pulses", 32'(crc_pulses - cb), 32'd0);
    run_frame("after_badpre", 60, 1'b0, 1'b0);

    run_frame("runt20", 20, 1'b0, 1'b0);
    run_frame("over1596", 1596, 1'b0, 1'b0);

    gap_mode = 1'b1;
    run_frame("gaps60", 60, 1'b0, 1'b0);
    gap_mode = 1'b0;

    // Reset in the middle of a frame while a beat is on the bus
    fill(60, 1'b0);
    b = got_q.size();
    send_frame(1'b0, 1'b0, 6);
    @(posedge clk);
    #1;
    chk("midframe tvalid before reset", 32'(tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset tvalid", 32'(tvalid), 32'd0);
    chk("midreset tdata", tdata, 32'd0);
    chk("midreset tkeep", 32'(tkeep), 32'd0);
    chk("midreset tlast", 32'(tlast), 32'd0);
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    nlast = 0;
    for (int i = b; i < got_q.size(); i++) if (got_q[i].last) nlast++;
    chk("midreset no tlast", 32'(nlast), 32'd0);
    rst_n = 1'b1;
    ctrl  = 4'hF;
    rxd   = 32'h07070707;
    @(negedge clk);
    run_frame("after_reset", 60, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      gap_mode = ($urandom_range(0, 2) == 0);
      run_frame($sformatf("rand%0d", n), int'($urandom_range(46, 200)), 1'b0,
                ($urandom_range(0, 2) == 0));
    end
    gap_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
